// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute-stage results and controls for memory_stage.
// Optional misaligned-access check enabled by defining MEM_MISALIGN_CHECK_EN.
module ex_mem_register #(
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          REG_ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR     = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      EX_stall_i,
  input  logic                      EX_flush_i,
  input  logic                      EX_valid_i,
  input  logic                      EX_RegWrite_i,
  input  logic                      EX_MemWrite_i,
  input  logic                      EX_MemRead_i,
  input  logic                      EX_MemToReg_i,
  input  logic [DATA_WIDTH-1:0]     EX_instruction_i,
  input  logic [DATA_WIDTH-1:0]     EX_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     EX_wr_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] EX_rd_i,
  input  logic [DATA_WIDTH-1:0]     EX_pc_plus4_i,
  output logic                      MEM_valid_o,
  output logic                      MEM_RegWrite_o,
  output logic                      MEM_MemWrite_o,
  output logic                      MEM_MemRead_o,
  output logic                      MEM_MemToReg_o,
  output logic [DATA_WIDTH-1:0]     MEM_instruction_o,
  output logic [DATA_WIDTH-1:0]     MEM_rd_addr_o,
  output logic [DATA_WIDTH-1:0]     MEM_wr_data_o,
  output logic [REG_ADDR_WIDTH-1:0] MEM_rd_o,
  output logic [DATA_WIDTH-1:0]     MEM_pc_plus4_o,
  output logic                      MEM_misalign_o
);

  logic misalign_c;
  logic allow_c;

`ifdef MEM_MISALIGN_CHECK_EN
  // Access-size alignment from funct3[1:0]; only real memory ops are checked
  always_comb begin
    misalign_c = 1'b0;
    if (EX_valid_i && (EX_MemRead_i || EX_MemWrite_i)) begin
      case (EX_instruction_i[13:12])
        2'b00:   misalign_c = 1'b0;
        2'b01:   misalign_c = EX_alu_result_i[0];
        2'b10:   misalign_c = |EX_alu_result_i[1:0];
        default: misalign_c = 1'b1;
      endcase
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Side-effecting controls survive only for valid, aligned instructions
  assign allow_c = EX_valid_i && !misalign_c;

  always_ff @(posedge clk) begin
    if (rst || EX_flush_i) begin
      MEM_valid_o       <= 1'b0;
      MEM_RegWrite_o    <= 1'b0;
      MEM_MemWrite_o    <= 1'b0;
      MEM_MemRead_o     <= 1'b0;
      MEM_MemToReg_o    <= 1'b0;
      MEM_instruction_o <= NOP_INSTR;
      MEM_rd_addr_o     <= '0;
      MEM_wr_data_o     <= '0;
      MEM_rd_o          <= '0;
      MEM_pc_plus4_o    <= '0;
      MEM_misalign_o    <= 1'b0;
    end else if (!EX_stall_i) begin
      MEM_valid_o       <= EX_valid_i;
      MEM_RegWrite_o    <= EX_RegWrite_i && allow_c;
      MEM_MemWrite_o    <= EX_MemWrite_i && allow_c;
      MEM_MemRead_o     <= EX_MemRead_i && allow_c;
      MEM_MemToReg_o    <= EX_MemToReg_i;
      MEM_instruction_o <= EX_instruction_i;
      MEM_rd_addr_o     <= EX_alu_result_i;
      MEM_wr_data_o     <= EX_wr_data_i;
      MEM_rd_o          <= EX_rd_i;
      MEM_pc_plus4_o    <= EX_pc_plus4_i;
      MEM_misalign_o    <= misalign_c;
    end
  end

endmodule

// File: tb/tb_ex_mem_register.sv
// Self-checking bench for ex_mem_register: per-cycle model comparison plus directed literal checks.
module tb_ex_mem_register;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid, rw, mw, mr, m2r;
  logic [31:0] instr, alu, wd, pc4;
  logic [4:0]  rd;

  logic        o_valid, o_rw, o_mw, o_mr, o_m2r, o_mis;
  logic [31:0] o_instr, o_addr, o_wd, o_pc4;
  logic [4:0]  o_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_register dut (
    .clk(clk), .rst(rst),
    .EX_stall_i(stall), .EX_flush_i(flush), .EX_valid_i(valid),
    .EX_RegWrite_i(rw), .EX_MemWrite_i(mw), .EX_MemRead_i(mr), .EX_MemToReg_i(m2r),
    .EX_instruction_i(instr), .EX_alu_result_i(alu), .EX_wr_data_i(wd),
    .EX_rd_i(rd), .EX_pc_plus4_i(pc4),
    .MEM_valid_o(o_valid), .MEM_RegWrite_o(o_rw), .MEM_MemWrite_o(o_mw),
    .MEM_MemRead_o(o_mr), .MEM_MemToReg_o(o_m2r), .MEM_instruction_o(o_instr),
    .MEM_rd_addr_o(o_addr), .MEM_wr_data_o(o_wd), .MEM_rd_o(o_rd),
    .MEM_pc_plus4_o(o_pc4), .MEM_misalign_o(o_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stage register must hold after each edge
  bit          m_ok = 1'b0;
  logic        e_valid, e_rw, e_mw, e_mr, e_m2r, e_mis;
  logic [31:0] e_instr, e_addr, e_wd, e_pc4;
  logic [4:0]  e_rd;

  function automatic bit model_misaligned(input logic [31:0] ins, input logic [31:0] addr,
                                          input logic v, input logic r, input logic w);
    int unsigned sz_log2;
    if (!MIS_EN || !v || !(r || w)) return 1'b0;
    sz_log2 = int'(ins[13:12]);
    if (sz_log2 == 3) return 1'b1;
    return (addr % (32'd1 << sz_log2)) != 0;
  endfunction

  always @(posedge clk) begin
    bit bad;
    if (rst || flush) begin
      {e_valid, e_rw, e_mw, e_mr, e_m2r, e_mis} = '0;
      e_instr = 32'h0000_0013;
      e_addr = 0; e_wd = 0; e_pc4 = 0; e_rd = 0;
      if (rst) m_ok = 1'b1;
    end else if (!stall) begin
      bad     = model_misaligned(instr, alu, valid, mr, mw);
      e_valid = valid;
      e_rw    = rw & valid & !bad;
      e_mw    = mw & valid & !bad;
      e_mr    = mr & valid & !bad;
      e_m2r   = m2r;
      e_mis   = bad;
      e_instr = instr; e_addr = alu; e_wd = wd; e_pc4 = pc4; e_rd = rd;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_valid", 32'(o_valid), 32'(e_valid));
      chk("m_regwrite", 32'(o_rw), 32'(e_rw));
      chk("m_memwrite", 32'(o_mw), 32'(e_mw));
      chk("m_memread", 32'(o_mr), 32'(e_mr));
      chk("m_memtoreg", 32'(o_m2r), 32'(e_m2r));
      chk("m_misalign", 32'(o_mis), 32'(e_mis));
      chk("m_instr", o_instr, e_instr);
      chk("m_addr", o_addr, e_addr);
      chk("m_wdata", o_wd, e_wd);
      chk("m_rd", 32'(o_rd), 32'(e_rd));
      chk("m_pc4", o_pc4, e_pc4);
    end
  end

  task automatic drive(input logic s, input logic f, input logic v, input logic r_w,
                       input logic m_w, input logic m_r, input logic m2, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdi,
                       input logic [31:0] p);
    stall = s; flush = f; valid = v; rw = r_w; mw = m_w; mr = m_r; m2r = m2;
    instr = ins; alu = a; wd = d; rd = rdi; pc4 = p;
  endtask

  task automatic randomize_inputs();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), $urandom);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    randomize_inputs();
    cyc();
    chk("rst_instr", o_instr, 32'h0000_0013);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ctrl", 32'({o_rw, o_mw, o_mr, o_m2r, o_mis}), 32'd0);
    chk("rst_data", o_addr | o_wd | o_pc4 | 32'(o_rd), 32'd0);
    randomize_inputs();
    cyc();
    chk("rst2_instr", o_instr, 32'h0000_0013);
    rst = 1'b0;

    // lw x6, 0x100
    drive(0, 0, 1, 1, 0, 1, 1, 32'h0002_A303, 32'h100, 32'h5555, 5'd6, 32'h1004);
    cyc();
    chk("lw_addr", o_addr, 32'h100);
    chk("lw_rd", 32'(o_rd), 32'd6);
    chk("lw_ctrl", 32'({o_valid, o_rw, o_mr, o_m2r, o_mw}), 32'b11110);
    chk("lw_pc4", o_pc4, 32'h1004);

    // sw to 0x200, then hold for 3 cycles with changing inputs
    drive(0, 0, 1, 0, 1, 0, 0, 32'h00A2_A023, 32'h200, 32'hDEAD_BEEF, 5'd0, 32'h1008);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 0, 1, 1, $urandom, $urandom, $urandom, 5'($urandom), $urandom);
      cyc();
      chk("stall_addr", o_addr, 32'h200);
      chk("stall_wdata", o_wd, 32'hDEAD_BEEF);
      chk("stall_memwrite", 32'(o_mw), 32'd1);
    end

    // Flush wins over stall
    drive(1, 1, 1, 1, 1, 1, 1, 32'h1234_5678, 32'h300, 32'h77, 5'd9, 32'h2000);
    cyc();
    chk("flush_instr", o_instr, 32'h0000_0013);
    chk("flush_ctrl", 32'({o_valid, o_rw, o_mw, o_mr, o_m2r}), 32'd0);

    // Invalid instruction: side-effect controls dropped, data captured
    drive(0, 0, 0, 1, 1, 0, 1, 32'h00A2_A023, 32'h440, 32'hCAFE, 5'd3, 32'h2004);
    cyc();
    chk("inv_memwrite", 32'(o_mw), 32'd0);
    chk("inv_valid", 32'(o_valid), 32'd0);
    chk("inv_regwrite", 32'(o_rw), 32'd0);
    chk("inv_addr", o_addr, 32'h440);

    // x0 destination passes through untouched
    drive(0, 0, 1, 1, 0, 0, 0, 32'h0000_0033, 32'h9, 32'h0, 5'd0, 32'h2008);
    cyc();
    chk("x0_regwrite", 32'(o_rw), 32'd1);
    chk("x0_rd", 32'(o_rd), 32'd0);

    // Reset during a stall drops the held instruction; next load is normal
    drive(1, 0, 1, 1, 0, 1, 1, 32'h0002_A303, 32'h500, 32'h1, 5'd7, 32'h3000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rststall_instr", o_instr, 32'h0000_0013);
    chk("rststall_rd", 32'(o_rd), 32'd0);
    drive(0, 0, 1, 1, 0, 1, 1, 32'h0002_A303, 32'h504, 32'h2, 5'd8, 32'h3004);
    cyc();
    chk("postrst_addr", o_addr, 32'h504);
    chk("postrst_rd", 32'(o_rd), 32'd8);

    // Alignment cases
    drive(0, 0, 1, 0, 1, 0, 0, 32'h00A2_A023, 32'h102, 32'h11, 5'd0, 32'h4000);
    cyc();
    chk("sw102_mis", 32'(o_mis), 32'(MIS_EN));
    chk("sw102_mw", 32'(o_mw), 32'(!MIS_EN));
    chk("sw102_valid", 32'(o_valid), 32'd1);
    chk("sw102_addr", o_addr, 32'h102);
    drive(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    cyc();
    chk("stall_mis", 32'(o_mis), 32'(MIS_EN));
    drive(0, 0, 1, 0, 1, 0, 0, 32'h00A2_9023, 32'h102, 32'h22, 5'd0, 32'h4004);
    cyc();
    chk("sh102_mis", 32'(o_mis), 32'd0);
    chk("sh102_mw", 32'(o_mw), 32'd1);
    drive(0, 0, 1, 1, 0, 1, 1, 32'h0002_9303, 32'h103, 32'h0, 5'd6, 32'h4008);
    cyc();
    chk("lh103_mis", 32'(o_mis), 32'(MIS_EN));
    chk("lh103_mr", 32'(o_mr), 32'(!MIS_EN));
    chk("lh103_rw", 32'(o_rw), 32'(!MIS_EN));
    chk("lh103_instr", o_instr, 32'h0002_9303);
    // funct3[1:0]=11 with a memory op
    drive(0, 0, 1, 0, 0, 1, 0, 32'h0000_B003, 32'h100, 32'h0, 5'd1, 32'h400C);
    cyc();
    chk("f11_mis", 32'(o_mis), 32'(MIS_EN));
    // Byte access at odd address, then a flush clears any flag
    drive(0, 0, 1, 0, 1, 0, 0, 32'h00A2_8023, 32'h107, 32'h0, 5'd0, 32'h4010);
    cyc();
    chk("sb107_mis", 32'(o_mis), 32'd0);
    chk("sb107_mw", 32'(o_mw), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    cyc();
    chk("flush_mis", 32'(o_mis), 32'd0);

    // Random traffic checked by the model only
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 31) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
